// File: rtl/rv32i_encoder.sv
// RV32I I-type encoder: {mnemonic, rd, rs1, imm} -> machine word + imem address, via a 2-entry queue.
// Optional immediate range checking is enabled by defining RV32I_ENC_RANGE_CHECK_EN.
package fe_pkg;
    typedef enum logic [4:0] {
        NULL, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, LUI
    } RV32I_INSTRUCTION_MNEMONIC_t;
    typedef logic [4:0]  RV32I_RD_t;
    typedef logic [4:0]  RV32I_RS1_t;
    typedef logic [31:0] RV32I_IMM_t;
endpackage

module rv32i_encoder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0040_0000,
    parameter int          IMEM_DEPTH = 1024,
    parameter int          ADDR_W     = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  fe_pkg::RV32I_INSTRUCTION_MNEMONIC_t   mnemonic,
    input  fe_pkg::RV32I_RD_t                     rd,
    input  fe_pkg::RV32I_RS1_t                    rs1,
    input  fe_pkg::RV32I_IMM_t                    imm,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [31:0]                           out_instr,
    output logic [ADDR_W-1:0]                     out_addr,
    output logic [1:0]                            count,
    output logic                                  err_illegal,
    output logic                                  err_range
);
    import fe_pkg::*;

    localparam logic [6:0]        OPC_IMM = 7'h13;
    localparam logic [31:0]       NOP     = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A  = BASE_A + ADDR_W'(4 * (IMEM_DEPTH - 1));

`ifdef RV32I_ENC_RANGE_CHECK_EN
    function automatic logic imm_out_of_range(input logic signed [31:0] v, input logic is_shift);
        if (is_shift)
            return (v < 0) || (v > 31);
        return (v < -2048) || (v > 2047);
    endfunction
`endif

    logic [2:0]        f3_p0;
    logic [6:0]        f7_p0;
    logic              legal_p0;
    logic              shift_p0;
    logic [31:0]       enc_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic              vld_p0;
    logic              pop;
    logic [ADDR_W-1:0] ctr;
    logic [31:0]       tail_instr_p1;
    logic [ADDR_W-1:0] tail_addr_p1;
    logic              unused_imm_hi;

    // Upper immediate bits only matter to the optional range check.
    assign unused_imm_hi = ^imm[31:12];

    // Stage p0: combinational encode of the incoming request
    always_comb begin
        f3_p0    = 3'd0;
        f7_p0    = 7'h00;
        legal_p0 = 1'b1;
        shift_p0 = 1'b0;
        case (mnemonic)
            ADDI:    f3_p0 = 3'd0;
            SLTI:    f3_p0 = 3'd2;
            SLTIU:   f3_p0 = 3'd3;
            XORI:    f3_p0 = 3'd4;
            ORI:     f3_p0 = 3'd6;
            ANDI:    f3_p0 = 3'd7;
            SLLI:    begin f3_p0 = 3'd1; shift_p0 = 1'b1; end
            SRLI:    begin f3_p0 = 3'd5; shift_p0 = 1'b1; end
            SRAI:    begin f3_p0 = 3'd5; f7_p0 = 7'h20; shift_p0 = 1'b1; end
            default: legal_p0 = 1'b0;
        endcase
        if (!legal_p0)
            enc_p0 = NOP;
        else if (shift_p0)
            enc_p0 = {f7_p0, imm[4:0], rs1, f3_p0, rd, OPC_IMM};
        else
            enc_p0 = {imm[11:0], rs1, f3_p0, rd, OPC_IMM};
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign vld_p0    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    // A start in the same cycle as an accept hands that word the base address.
    assign addr_p0   = start ? BASE_A : ctr;

    // Stage p1: queue head drives the outputs directly, tail is the second slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctr           <= BASE_A;
            count         <= 2'd0;
            out_instr     <= 32'd0;
            out_addr      <= '0;
            tail_instr_p1 <= 32'd0;
            tail_addr_p1  <= '0;
            err_illegal   <= 1'b0;
`ifdef RV32I_ENC_RANGE_CHECK_EN
            err_range     <= 1'b0;
`endif
        end else begin
            if (vld_p0)
                ctr <= (addr_p0 == LAST_A) ? BASE_A : addr_p0 + ADDR_W'(4);
            else if (start)
                ctr <= BASE_A;

            err_illegal <= (err_illegal & ~start) | (vld_p0 & ~legal_p0);
`ifdef RV32I_ENC_RANGE_CHECK_EN
            err_range   <= (err_range & ~start) |
                           (vld_p0 & legal_p0 & imm_out_of_range(signed'(imm), shift_p0));
`endif

            case ({vld_p0, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        out_instr <= enc_p0;
                        out_addr  <= addr_p0;
                    end else begin
                        tail_instr_p1 <= enc_p0;
                        tail_addr_p1  <= addr_p0;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    out_instr <= tail_instr_p1;
                    out_addr  <= tail_addr_p1;
                    count     <= count - 2'd1;
                end
                // Push with pop only happens at count==1: new word replaces the head.
                2'b11: begin
                    out_instr <= enc_p0;
                    out_addr  <= addr_p0;
                end
                default: ;
            endcase
        end
    end

`ifndef RV32I_ENC_RANGE_CHECK_EN
    assign err_range = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_encoder.sv
// Scoreboard bench for rv32i_encoder: a default-parameter instance plus a small wrap-test instance.
module tb_rv32i_encoder;
    import fe_pkg::*;

`ifdef RV32I_ENC_RANGE_CHECK_EN
    localparam logic EXP_RANGE = 1'b1;
`else
    localparam logic EXP_RANGE = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst, start, in_valid, in_ready, out_valid, out_ready;
    RV32I_INSTRUCTION_MNEMONIC_t mnemonic;
    logic [4:0]  rd, rs1;
    logic [31:0] imm, out_instr, out_addr;
    logic [1:0]  count;
    logic        err_illegal, err_range;

    logic start2, in_valid2, in_ready2, out_valid2, out_ready2;
    logic [31:0] out_instr2, out_addr2;
    logic [1:0]  count2;
    logic        err_illegal2, err_range2;

    exp_t sb[$];
    exp_t sb2[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rv32i_encoder dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .mnemonic(mnemonic), .rd(rd), .rs1(rs1), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .count(count), .err_illegal(err_illegal), .err_range(err_range)
    );

    rv32i_encoder #(.BASE_ADDR(32'h0), .IMEM_DEPTH(4), .ADDR_W(32)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
        .mnemonic(ADDI), .rd(5'd1), .rs1(5'd0), .imm(32'd0),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2), .out_addr(out_addr2),
        .count(count2), .err_illegal(err_illegal2), .err_range(err_range2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop the scoreboard whenever a head entry is consumed
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got %h @%h, expected none", out_instr, out_addr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_instr", out_instr, e.instr);
                check("out_addr", out_addr, e.addr);
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid2 && out_ready2) begin
            if (sb2.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output2: got %h @%h, expected none", out_instr2, out_addr2);
            end else begin
                exp_t e;
                e = sb2.pop_front();
                check("wrap_instr", out_instr2, e.instr);
                check("wrap_addr", out_addr2, e.addr);
            end
        end
    end

    task automatic send(input RV32I_INSTRUCTION_MNEMONIC_t m, input logic [4:0] r_d,
                        input logic [4:0] r_s1, input logic [31:0] im,
                        input logic [31:0] exp_w, input logic [31:0] exp_a, input logic st);
        bit ok = 1'b0;
        mnemonic = m; rd = r_d; rs1 = r_s1; imm = im; start = st; in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=0, expected 1 for word %h", exp_w);
        end else begin
            sb.push_back('{instr: exp_w, addr: exp_a});
        end
        @(posedge clk); #1;
        in_valid = 1'b0; start = 1'b0;
    endtask

    task automatic send2(input logic [31:0] exp_a);
        bit ok = 1'b0;
        in_valid2 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready2) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout2: in_ready=0, expected 1");
        end else begin
            sb2.push_back('{instr: 32'h0000_0093, addr: exp_a});
        end
        @(posedge clk); #1;
        in_valid2 = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (sb.size() != 0 || sb2.size() != 0); i++)
            @(negedge clk);
        checks++;
        if (sb.size() != 0 || sb2.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d/%0d, expected 0/0", sb.size(), sb2.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        mnemonic = NULL; rd = '0; rs1 = '0; imm = '0;
        start2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_addr", out_addr, 32'd0);
        check("rst_err_illegal", 32'(err_illegal), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;

        send(ADDI, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'hFFF1_0093, 32'h0040_0000, 1'b0);
        check("latency_out_valid", 32'(out_valid), 32'd1);
        send(SRAI, 5'd3, 5'd4, 32'd5, 32'h4052_5193, 32'h0040_0004, 1'b0);
        send(SRLI, 5'd3, 5'd4, 32'd5, 32'h0052_5193, 32'h0040_0008, 1'b0);
        send(SLTI, 5'd5, 5'd6, 32'd100, 32'h0643_2293, 32'h0040_000C, 1'b0);
        send(SLTIU, 5'd1, 5'd1, 32'd1, 32'h0010_B093, 32'h0040_0010, 1'b0);
        send(XORI, 5'd7, 5'd8, 32'h7FF, 32'h7FF4_4393, 32'h0040_0014, 1'b0);
        send(ORI, 5'd31, 5'd31, 32'hFFFF_F800, 32'h800F_EF93, 32'h0040_0018, 1'b0);
        send(ANDI, 5'd0, 5'd0, 32'hFF, 32'h0FF0_7013, 32'h0040_001C, 1'b0);
        send(SLLI, 5'd2, 5'd3, 32'd31, 32'h01F1_9113, 32'h0040_0020, 1'b0);
        check("err_illegal_clean", 32'(err_illegal), 32'd0);
        send(NULL, 5'd1, 5'd2, 32'd3, 32'h0000_0013, 32'h0040_0024, 1'b0);
        check("err_illegal_null", 32'(err_illegal), 32'd1);
        send(ADD, 5'd1, 5'd2, 32'd3, 32'h0000_0013, 32'h0040_0028, 1'b0);
        drain();

        // Backpressure: third request must stall until the consumer drains
        out_ready = 1'b0;
        fork
            begin
                send(ADDI, 5'd1, 5'd0, 32'd1, 32'h0010_0093, 32'h0040_002C, 1'b0);
                send(ADDI, 5'd1, 5'd0, 32'd2, 32'h0020_0093, 32'h0040_0030, 1'b0);
                send(ADDI, 5'd1, 5'd0, 32'd3, 32'h0030_0093, 32'h0040_0034, 1'b0);
            end
        join_none
        repeat (5) @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_count", 32'(count), 32'd2);
        check("bp_head_instr", out_instr, 32'h0010_0093);
        @(negedge clk);
        check("bp_hold_instr", out_instr, 32'h0010_0093);
        check("bp_hold_addr", out_addr, 32'h0040_002C);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        repeat (2) @(posedge clk);
        #1;

        // start clears sticky errors and rewinds the counter
        pulse_start();
        check("start_clears_err", 32'(err_illegal), 32'd0);
        send(ADDI, 5'd1, 5'd0, 32'd1, 32'h0010_0093, 32'h0040_0000, 1'b0);
        send(NULL, 5'd0, 5'd0, 32'd0, 32'h0000_0013, 32'h0040_0000, 1'b1);
        check("start_accept_err_kept", 32'(err_illegal), 32'd1);
        send(ADDI, 5'd1, 5'd0, 32'd2, 32'h0020_0093, 32'h0040_0004, 1'b0);
        send(ADDI, 5'd1, 5'd1, 32'd2048, 32'h8000_8093, 32'h0040_0008, 1'b0);
        check("err_range", 32'(err_range), 32'(EXP_RANGE));
        drain();

        // Asynchronous reset with a full queue
        out_ready = 1'b0;
        send(ADDI, 5'd1, 5'd0, 32'd3, 32'h0030_0093, 32'h0040_000C, 1'b0);
        send(ADDI, 5'd1, 5'd0, 32'd4, 32'h0040_0093, 32'h0040_0010, 1'b0);
        check("full_count", 32'(count), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_count", 32'(count), 32'd0);
        check("async_err_illegal", 32'(err_illegal), 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1; out_ready = 1'b1;
        send(ADDI, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'hFFF1_0093, 32'h0040_0000, 1'b0);
        drain();

        // Address wrap on the 4-word instance, then start rewinds mid-stream
        send2(32'd0);
        send2(32'd4);
        send2(32'd8);
        send2(32'd12);
        send2(32'd0);
        send2(32'd4);
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        send2(32'd0);
        send2(32'd4);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end
endmodule
